// File: rtl/quad_enc_decoder.sv
// quad_enc_decoder: synchronizes, glitch-filters and 4x-decodes one quadrature
// encoder channel into step/dir pulses, a signed position count, index and
// snapshot captures, and a sticky illegal-transition flag.
module quad_enc_decoder #(
   parameter int CNT_WIDTH = 32,
   parameter int FILT_LEN  = 4
) (
   input  logic                 clk,
   input  logic                 aclr_n,
   input  logic                 sclr,
   input  logic                 A,
   input  logic                 B,
   input  logic                 Z,
   input  logic                 snapshot,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   input  logic                 err_clr,
   output logic                 step,
   output logic                 dir,
   output logic [CNT_WIDTH-1:0] pos,
   output logic [CNT_WIDTH-1:0] snap_pos,
   output logic                 changed,
   output logic [CNT_WIDTH-1:0] idx_pos,
   output logic                 idx_valid,
   output logic                 err
);
   localparam logic [7:0]           FL_M1  = 8'(FILT_LEN - 1);
   localparam logic [8:0]           SETTLE = 9'(FILT_LEN + 3);
   localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

   // pin vectors are ordered {A, B, Z}
   logic [2:0]           r_sync1, r_sync2, r_filt, r_prev;
   logic [7:0]           r_fcnt [3];
   logic [8:0]           r_settle;
   logic                 r_step, r_dir, r_changed, r_idx_valid, r_err;
   logic [CNT_WIDTH-1:0] r_pos, r_snap, r_idx;
   logic [1:0]           w_diff;
   logic                 w_settled, w_edge, w_dbl, w_up, w_zrise;

   assign w_settled = (r_settle == 9'd0);
   assign w_diff    = r_filt[2:1] ^ r_prev[2:1];
   assign w_edge    = w_settled & ^w_diff;
   assign w_dbl     = w_settled & &w_diff;
   // up sequence 00->10->11->01: new A differs from previous B
   assign w_up      = r_filt[2] ^ r_prev[1];
   assign w_zrise   = w_settled & r_filt[0] & ~r_prev[0];

   assign step      = r_step;
   assign dir       = r_dir;
   assign pos       = r_pos;
   assign snap_pos  = r_snap;
   assign changed   = r_changed;
   assign idx_pos   = r_idx;
   assign idx_valid = r_idx_valid;
   assign err       = r_err;

   // two-flop synchronizers, per-pin persistence filters, previous state and settle window
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_filt   <= '0;
         r_prev   <= '0;
         r_settle <= SETTLE;
         for (int i = 0; i < 3; i++) r_fcnt[i] <= '0;
      end else if (sclr) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_filt   <= '0;
         r_prev   <= '0;
         r_settle <= SETTLE;
         for (int i = 0; i < 3; i++) r_fcnt[i] <= '0;
      end else begin
         r_sync1  <= {A, B, Z};
         r_sync2  <= r_sync1;
         r_prev   <= r_filt;
         r_settle <= w_settled ? 9'd0 : r_settle - 9'd1;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_filt[i]) r_fcnt[i] <= '0;
            else if (r_fcnt[i] == FL_M1) begin
               r_filt[i] <= r_sync2[i];
               r_fcnt[i] <= '0;
            end else r_fcnt[i] <= r_fcnt[i] + 8'd1;
         end
      end
   end

   // decode edges into step/dir/pos, capture snapshot and index positions, track errors
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_step      <= 1'b0;
         r_dir       <= 1'b0;
         r_pos       <= '0;
         r_snap      <= '0;
         r_changed   <= 1'b0;
         r_idx       <= '0;
         r_idx_valid <= 1'b0;
         r_err       <= 1'b0;
      end else if (sclr) begin
         r_step      <= 1'b0;
         r_dir       <= 1'b0;
         r_pos       <= '0;
         r_snap      <= '0;
         r_changed   <= 1'b0;
         r_idx       <= '0;
         r_idx_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_step <= w_edge;
         if (w_edge) r_dir <= w_up;
         if (load) r_pos <= load_val;
         else if (w_edge) r_pos <= r_pos + (w_up ? ONE : '1);
         if (snapshot) begin
            r_snap    <= r_pos;
            r_changed <= (r_pos != r_snap);
         end
         if (w_zrise) begin
            r_idx       <= r_pos;
            r_idx_valid <= 1'b1;
         end
         if (w_dbl) r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_quad_enc_decoder.sv
// tb_quad_enc_decoder: directed and randomized checks of quad_enc_decoder against a
// phase-index / integer-position reference model.
module tb_quad_enc_decoder;
   logic        clk = 1'b0;
   logic        aclr_n = 1'b0;
   logic        sclr = 1'b0;
   logic        A = 1'b1, B = 1'b1, Z = 1'b0;
   logic        snapshot = 1'b0, load = 1'b0, err_clr = 1'b0;
   logic [31:0] load_val = '0;
   logic        step, dir, changed, idx_valid, err;
   logic [31:0] pos, snap_pos, idx_pos;

   quad_enc_decoder #(.CNT_WIDTH(32), .FILT_LEN(4)) dut (
      .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .A(A), .B(B), .Z(Z),
      .snapshot(snapshot), .load(load), .load_val(load_val), .err_clr(err_clr),
      .step(step), .dir(dir), .pos(pos), .snap_pos(snap_pos), .changed(changed),
      .idx_pos(idx_pos), .idx_valid(idx_valid), .err(err)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, step_cnt = 0;

   // count step pulses away from the active edge
   always @(negedge clk) if (step === 1'b1) step_cnt++;

   // reference model: Gray phase index (0..3 along the up sequence) and position
   logic [1:0]  gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   int          phase = 2;
   logic [31:0] m_pos = '0, m_snap = '0;
   logic        m_dir = 1'b0, m_changed = 1'b0;
   int          s0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // drive the next Gray state in the chosen direction and update the model
   task automatic set_move(input bit up);
      phase = up ? (phase + 1) % 4 : (phase + 3) % 4;
      {A, B} = gray[phase];
      m_pos = up ? m_pos + 32'd1 : m_pos - 32'd1;
      m_dir = up;
   endtask

   task automatic move(input bit up, input int hold);
      set_move(up);
      tick(hold);
   endtask

   task automatic do_snapshot();
      m_changed = (m_pos != m_snap);
      m_snap = m_pos;
      snapshot = 1'b1;
      tick(1);
      snapshot = 1'b0;
      tick(2);
   endtask

   task automatic do_load(input logic [31:0] v);
      load_val = v;
      load = 1'b1;
      tick(1);
      load = 1'b0;
      m_pos = v;
      tick(2);
   endtask

   initial begin
      // reset with both phases high
      tick(3);
      chk("rst_pos", pos, 32'd0);
      chk("rst_step", {31'd0, step}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      aclr_n = 1'b1;
      tick(20);
      chk("settle_steps", step_cnt, 0);
      chk("settle_pos", pos, 32'd0);
      chk("settle_err", {31'd0, err}, 32'd0);
      chk("settle_idx_valid", {31'd0, idx_valid}, 32'd0);

      // 8 forward, 3 reverse edges
      s0 = step_cnt;
      for (int i = 0; i < 8; i++) move(1'b1, 10);
      chk("fwd_steps", step_cnt - s0, 8);
      chk("fwd_dir", {31'd0, dir}, {31'd0, m_dir});
      chk("fwd_pos", pos, 32'd8);
      for (int i = 0; i < 3; i++) move(1'b0, 10);
      chk("rev_dir", {31'd0, dir}, 32'd0);
      chk("rev_pos", pos, 32'd5);

      // 3-cycle glitch is rejected
      s0 = step_cnt;
      {A, B} = gray[(phase + 1) % 4];
      tick(3);
      {A, B} = gray[phase];
      tick(12);
      chk("glitch3_steps", step_cnt - s0, 0);
      chk("glitch3_pos", pos, m_pos);

      // 4-cycle glitch passes as a forward then reverse edge
      {A, B} = gray[(phase + 1) % 4];
      tick(4);
      {A, B} = gray[phase];
      tick(4);
      chk("glitch4_mid_pos", pos, m_pos + 32'd1);
      tick(10);
      chk("glitch4_steps", step_cnt - s0, 2);
      chk("glitch4_pos", pos, m_pos);
      chk("glitch4_dir", {31'd0, dir}, 32'd0);
      m_dir = 1'b0;

      // random walk
      s0 = step_cnt;
      for (int i = 0; i < 24; i++) move(1'($urandom_range(0, 1)), $urandom_range(5, 12));
      tick(10);
      chk("rand_steps", step_cnt - s0, 24);
      chk("rand_pos", pos, m_pos);
      chk("rand_dir", {31'd0, dir}, {31'd0, m_dir});

      // double transition sets err, leaves pos and dir
      s0 = step_cnt;
      phase = (phase + 2) % 4;
      {A, B} = gray[phase];
      tick(10);
      chk("dbl_err", {31'd0, err}, 32'd1);
      chk("dbl_pos", pos, m_pos);
      chk("dbl_dir", {31'd0, dir}, {31'd0, m_dir});
      chk("dbl_steps", step_cnt - s0, 0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(2);
      chk("errclr", {31'd0, err}, 32'd0);
      // err_clr lands on the decode cycle of a new double transition
      phase = (phase + 2) % 4;
      {A, B} = gray[phase];
      tick(6);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(3);
      chk("errclr_coinc", {31'd0, err}, 32'd1);

      // wrap boundaries
      do_load(32'h7FFF_FFFF);
      chk("load_max", pos, 32'h7FFF_FFFF);
      move(1'b1, 10);
      chk("wrap_up", pos, 32'h8000_0000);
      do_load(32'h0);
      move(1'b0, 10);
      chk("wrap_down", pos, 32'hFFFF_FFFF);

      // load coincident with a decode edge: load wins, step and dir still occur
      s0 = step_cnt;
      set_move(1'b1);
      tick(6);
      load_val = 32'h1234_5678;
      load = 1'b1;
      tick(1);
      load = 1'b0;
      m_pos = 32'h1234_5678;
      tick(3);
      chk("load_coinc_pos", pos, m_pos);
      chk("load_coinc_steps", step_cnt - s0, 1);
      chk("load_coinc_dir", {31'd0, dir}, 32'd1);

      // snapshot coincident with an up edge at pos=10
      do_load(32'd10);
      set_move(1'b1);
      tick(6);
      m_changed = (32'd10 != m_snap);
      m_snap = 32'd10;
      snapshot = 1'b1;
      tick(1);
      snapshot = 1'b0;
      tick(3);
      chk("snap_coinc_snap", snap_pos, 32'd10);
      chk("snap_coinc_pos", pos, 32'd11);
      chk("snap_coinc_chg", {31'd0, changed}, {31'd0, m_changed});
      do_snapshot();
      chk("snap2_snap", snap_pos, 32'd11);
      chk("snap2_chg", {31'd0, changed}, 32'd1);
      do_snapshot();
      chk("snap3_snap", snap_pos, m_snap);
      chk("snap3_chg", {31'd0, changed}, 32'd0);

      // index capture at pos=-3, then sclr
      do_load(32'hFFFF_FFFD);
      chk("idx_pre_valid", {31'd0, idx_valid}, 32'd0);
      Z = 1'b1;
      tick(10);
      chk("idx_pos", idx_pos, 32'hFFFF_FFFD);
      chk("idx_valid", {31'd0, idx_valid}, 32'd1);
      s0 = step_cnt;
      sclr = 1'b1;
      tick(1);
      sclr = 1'b0;
      tick(1);
      chk("sclr_pos", pos, 32'd0);
      chk("sclr_idx_valid", {31'd0, idx_valid}, 32'd0);
      chk("sclr_err", {31'd0, err}, 32'd0);
      chk("sclr_snap", snap_pos, 32'd0);
      chk("sclr_dir", {31'd0, dir}, 32'd0);
      tick(20);
      chk("post_sclr_pos", pos, 32'd0);
      chk("post_sclr_steps", step_cnt - s0, 0);
      chk("post_sclr_idx_valid", {31'd0, idx_valid}, 32'd0);
      chk("post_sclr_err", {31'd0, err}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
